// File: rtl/dma_responder.sv
// DMA responder: moves words between BRAM port B and valid/ready streams, or fills BRAM.
// Optional feature macro DMA_ERR_EN adds o_dma_err for illegal types and address overflow.
module dma_responder #(
   parameter int          CNT_W      = 32,
   parameter logic [31:0] FILL_VALUE = 32'h0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_dma_grant,
   input  logic [31:0]      i_dma_addr,
   input  logic [CNT_W-1:0] i_dma_count,
   input  logic [2:0]       i_dma_type,
   output logic             o_dma_ack,
`ifdef DMA_ERR_EN
   output logic             o_dma_err,
`endif
   output logic [3:0]       o_web,
   output logic [31:0]      o_addrb,
   output logic [31:0]      o_dinb,
   input  logic [31:0]      i_doutb,
   output logic             o_tx_valid,
   output logic [31:0]      o_tx_data,
   input  logic             i_tx_ready,
   input  logic             i_rx_valid,
   input  logic [31:0]      i_rx_data,
   output logic             o_rx_ready
);

   localparam logic [2:0] T_MEM2STR = 3'b001;
   localparam logic [2:0] T_STR2MEM = 3'b010;
   localparam logic [2:0] T_FILL    = 3'b011;

   typedef enum logic [2:0] {
      IDLE, RD_ADDR, RD_DATA, RD_HOLD, WR, FILL, ACK, WAIT_DROP
   } state_t;

   state_t           state, state_d;
   logic [31:0]      addr;
   logic [CNT_W-1:0] count;
   logic             latch;
   logic             step;
   logic             last;
   logic             legal;
   logic             reject;

   assign last  = (count == CNT_W'(1));
   assign legal = (i_dma_type == T_MEM2STR) || (i_dma_type == T_STR2MEM) ||
                  (i_dma_type == T_FILL);

`ifdef DMA_ERR_EN
   localparam int SUM_W = CNT_W + 34;
   logic [SUM_W-1:0] end_addr;
   logic             overflow;
   logic             err;

   // One past the last byte touched; reaching exactly 2^32 is still in range.
   assign end_addr = SUM_W'({i_dma_addr[31:2], 2'b00}) + (SUM_W'(i_dma_count) << 2);
   assign overflow = (i_dma_count != '0) && (end_addr > (SUM_W'(1) << 32));
   assign reject   = !legal || overflow;
   assign o_dma_err = (state == ACK) && err;
`else
   assign reject = !legal;
`endif

   // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state;
      o_dma_ack  = 1'b0;
      o_web      = 4'h0;
      o_addrb    = 32'h0;
      o_dinb     = 32'h0;
      o_tx_valid = 1'b0;
      o_rx_ready = 1'b0;
      latch      = 1'b0;
      step       = 1'b0;
      case (state)
         IDLE: begin
            if (i_dma_grant) begin
               latch = 1'b1;
               if ((i_dma_count == '0) || reject) begin
                  state_d = ACK;
               end else begin
                  case (i_dma_type)
                     T_MEM2STR: state_d = RD_ADDR;
                     T_STR2MEM: state_d = WR;
                     default:   state_d = FILL;
                  endcase
               end
            end
         end
         RD_ADDR: begin
            o_addrb = addr;
            state_d = RD_DATA;
         end
         RD_DATA: begin
            o_addrb = addr;
            state_d = RD_HOLD;
         end
         RD_HOLD: begin
            o_tx_valid = 1'b1;
            if (i_tx_ready) begin
               step    = 1'b1;
               state_d = last ? ACK : RD_ADDR;
            end
         end
         WR: begin
            o_rx_ready = 1'b1;
            o_addrb    = addr;
            if (i_rx_valid) begin
               o_web   = 4'hF;
               o_dinb  = i_rx_data;
               step    = 1'b1;
               state_d = last ? ACK : WR;
            end
         end
         FILL: begin
            o_addrb = addr;
            o_web   = 4'hF;
            o_dinb  = FILL_VALUE;
            step    = 1'b1;
            state_d = last ? ACK : FILL;
         end
         ACK: begin
            o_dma_ack = 1'b1;
            state_d   = WAIT_DROP;
         end
         WAIT_DROP: begin
            // A grant left high after the ack must not restart; wait for it to drop.
            if (!i_dma_grant) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr      <= 32'h0;
         count     <= '0;
         o_tx_data <= 32'h0;
`ifdef DMA_ERR_EN
         err       <= 1'b0;
`endif
      end else begin
         if (latch) begin
            addr  <= i_dma_addr & 32'hFFFF_FFFC;
            count <= i_dma_count;
`ifdef DMA_ERR_EN
            err   <= reject;
`endif
         end else if (step) begin
            addr  <= addr + 32'd4;
            count <= count - CNT_W'(1);
         end
         if (state == RD_DATA) o_tx_data <= i_doutb;
      end
   end

endmodule

// File: tb/tb_dma_responder.sv
// Bench for dma_responder: directed scenarios plus randomized transfers checked against
// a word-level model of BRAM contents and stream traffic.
module tb_dma_responder;
   localparam int          CNT_W = 32;
   localparam logic [31:0] FILL  = 32'h5EED_F111;

   logic             clk;
   logic             rst_n;
   logic             i_dma_grant;
   logic [31:0]      i_dma_addr;
   logic [CNT_W-1:0] i_dma_count;
   logic [2:0]       i_dma_type;
   logic             o_dma_ack;
`ifdef DMA_ERR_EN
   logic             o_dma_err;
`endif
   logic [3:0]       o_web;
   logic [31:0]      o_addrb, o_dinb, i_doutb;
   logic             o_tx_valid, i_tx_ready, i_rx_valid, o_rx_ready;
   logic [31:0]      o_tx_data, i_rx_data;

   dma_responder #(.CNT_W(CNT_W), .FILL_VALUE(FILL)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_dma_grant(i_dma_grant), .i_dma_addr(i_dma_addr),
      .i_dma_count(i_dma_count), .i_dma_type(i_dma_type),
      .o_dma_ack(o_dma_ack),
`ifdef DMA_ERR_EN
      .o_dma_err(o_dma_err),
`endif
      .o_web(o_web), .o_addrb(o_addrb), .o_dinb(o_dinb), .i_doutb(i_doutb),
      .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
      .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_rx_ready(o_rx_ready)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [31:0] mem [logic [31:0]];
   logic [31:0] wr_addr_q[$], wr_data_q[$], tx_q[$], rx_src[$];
   int          wr_cyc_q[$], tx_cyc_q[$];
   int          ack_cnt = 0, ack_cyc = 0, err_cnt = 0, viol = 0, stall_cnt = 0, grant_cyc = 0;
   logic [2:0]  cur_type = 3'b000;
   int          tx_mode = 1, tx_hold = 0, rx_gap = 0;
   bit          rx_fire = 0, rx_phase = 0;
   bit          prev_ack = 0, prev_valid = 0, prev_ready = 0;
   logic [31:0] prev_data = 32'h0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time exhausted, required finish earlier");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return ~a;
   endfunction

   // BRAM port B: registered read, byte-enabled write.
   initial begin
      logic [31:0] w;
      i_doutb = 32'h0;
      forever begin
         @(posedge clk);
         w = rd(o_addrb);
         i_doutb <= w;
         if (o_web != 4'h0) begin
            for (int b = 0; b < 4; b++)
               if (o_web[b]) w[8*b +: 8] = o_dinb[8*b +: 8];
            mem[o_addrb] = w;
         end
      end
   end

   // Monitor: logs BRAM writes, stream handshakes, acks, and protocol violations.
   initial forever begin
      @(negedge clk);
      rx_fire = i_rx_valid && o_rx_ready;
      if (rst_n) begin
         if (o_web != 4'h0) begin
            wr_addr_q.push_back(o_addrb);
            wr_data_q.push_back(o_dinb);
            wr_cyc_q.push_back(cyc);
            if (o_web != 4'hF) viol++;
            if (cur_type != 3'b010 && cur_type != 3'b011) viol++;
            if (cur_type == 3'b010 && !rx_fire) viol++;
         end
         if (o_tx_valid && i_tx_ready) begin
            tx_q.push_back(o_tx_data);
            tx_cyc_q.push_back(cyc);
         end
         if (o_tx_valid && !i_tx_ready) stall_cnt++;
         if (prev_valid && !prev_ready && o_tx_valid && o_tx_data !== prev_data) viol++;
         if (o_tx_valid && o_rx_ready) viol++;
         if (o_dma_ack) begin
            ack_cnt++;
            ack_cyc = cyc;
            if (prev_ack) viol++;
         end
`ifdef DMA_ERR_EN
         if (o_dma_err) begin
            err_cnt++;
            if (!o_dma_ack) viol++;
         end
`endif
      end
      prev_ack   = o_dma_ack;
      prev_valid = o_tx_valid;
      prev_ready = i_tx_ready;
      prev_data  = o_tx_data;
   end

   // Stream sources: tx_ready pattern and an rx word queue with optional gaps.
   initial begin
      i_tx_ready = 1'b0;
      i_rx_valid = 1'b0;
      i_rx_data  = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         case (tx_mode)
            0: i_tx_ready = 1'b0;
            1: i_tx_ready = 1'b1;
            2: i_tx_ready = 1'($urandom_range(0, 1));
            default: begin
               if (tx_hold > 0) begin
                  i_tx_ready = 1'b0;
                  tx_hold--;
               end else begin
                  i_tx_ready = 1'b1;
               end
            end
         endcase
         rx_phase = !rx_phase;
         if (rx_fire && rx_src.size() > 0) rx_src.delete(0);
         if (!(i_rx_valid && !rx_fire)) begin
            if (rx_src.size() > 0 && (rx_gap == 0 || (rx_gap == 1 && rx_phase) ||
                (rx_gap == 2 && $urandom_range(0, 1) == 1))) begin
               i_rx_valid = 1'b1;
               i_rx_data  = rx_src[0];
            end else begin
               i_rx_valid = 1'b0;
            end
         end
      end
   end

   function automatic bit outs_zero();
      bit z;
      z = ({o_dma_ack, o_web, o_addrb, o_dinb, o_tx_valid, o_tx_data, o_rx_ready} === '0);
`ifdef DMA_ERR_EN
      z = z && (o_dma_err === 1'b0);
`endif
      return z;
   endfunction

   task automatic clear_logs();
      wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
      tx_q.delete(); tx_cyc_q.delete();
      stall_cnt = 0;
   endtask

   task automatic start_req(input logic [31:0] a, input logic [CNT_W-1:0] c, input logic [2:0] t);
      @(posedge clk);
      #1;
      i_dma_grant = 1'b1;
      i_dma_addr  = a;
      i_dma_count = c;
      i_dma_type  = t;
      cur_type    = t;
      grant_cyc   = cyc;
   endtask

   task automatic wait_ack(input int budget, input int base, output bit seen);
      seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         #1;
         if (ack_cnt > base) seen = 1;
      end
   endtask

   task automatic drop_grant();
      @(posedge clk);
      #1;
      i_dma_grant = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; i_dma_grant = 1'b0; i_dma_addr = 32'h0; i_dma_count = '0; i_dma_type = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (!outs_zero()) begin
         bad++;
         $display("FAIL reset_outputs: got ack=%b web=%h addrb=%h tx_valid=%b rx_ready=%b, required all 0",
                  o_dma_ack, o_web, o_addrb, o_tx_valid, o_rx_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (!outs_zero() || ack_cnt != 0) begin
         bad++;
         $display("FAIL idle_after_reset: got ack=%b web=%h acks=%0d, required idle zeros", o_dma_ack, o_web, ack_cnt);
      end
   endtask

   task automatic test_fill();
      bit seen;
      int base = ack_cnt;
      for (int i = 0; i < 4; i++) mem[32'h100 + 32'(i) * 32'd4] = 32'hBAD0_0000 + 32'(i);
      clear_logs();
      start_req(32'h100, 4, 3'b011);
      wait_ack(40, base, seen);
      drop_grant();
      repeat (3) @(negedge clk);
      total++;
      if (!seen || ack_cnt != base + 1) begin
         bad++;
         $display("FAIL fill_ack: got %0d acks, required 1", ack_cnt - base);
      end
      total++;
      if (wr_addr_q.size() != 4) begin
         bad++;
         $display("FAIL fill_count: got %0d writes, required 4", wr_addr_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (wr_addr_q[i] !== 32'h100 + 32'(i) * 32'd4 || wr_data_q[i] !== FILL ||
                wr_cyc_q[i] != grant_cyc + 1 + i || rd(32'h100 + 32'(i) * 32'd4) !== FILL) begin
               bad++;
               $display("FAIL fill_word%0d: got addr=%h data=%h cyc=+%0d, required addr=%h data=%h cyc=+%0d",
                        i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i] - grant_cyc,
                        32'h100 + 32'(i) * 32'd4, FILL, 1 + i);
            end
         end
      end
      total++;
      if (ack_cyc != grant_cyc + 5) begin
         bad++;
         $display("FAIL fill_ack_time: got ack at +%0d, required +5", ack_cyc - grant_cyc);
      end
   endtask

   task automatic test_mem2str();
      bit seen;
      int base = ack_cnt;
      mem[32'h40] = 32'hA5A5_0001;
      mem[32'h44] = 32'hA5A5_0002;
      clear_logs();
      tx_mode = 3;
      tx_hold = 5;
      start_req(32'h40, 2, 3'b001);
      wait_ack(60, base, seen);
      drop_grant();
      repeat (3) @(negedge clk);
      tx_mode = 1;
      total++;
      if (!seen || ack_cnt != base + 1) begin
         bad++;
         $display("FAIL m2s_ack: got %0d acks, required 1", ack_cnt - base);
      end
      total++;
      if (tx_q.size() != 2 || tx_q[0] !== 32'hA5A5_0001 || tx_q[1] !== 32'hA5A5_0002) begin
         bad++;
         $display("FAIL m2s_data: got %0d words first=%h, required 2 words A5A50001,A5A50002",
                  tx_q.size(), tx_q.size() > 0 ? tx_q[0] : 32'h0);
      end
      total++;
      if (stall_cnt < 2) begin
         bad++;
         $display("FAIL m2s_stall: got %0d valid-without-ready cycles, required >= 2", stall_cnt);
      end
      total++;
      if (wr_addr_q.size() != 0 || tx_cyc_q.size() != 2 || ack_cyc != tx_cyc_q[tx_cyc_q.size() - 1] + 1) begin
         bad++;
         $display("FAIL m2s_timing: got writes=%0d ack at %0d, required no writes and ack after last beat",
                  wr_addr_q.size(), ack_cyc);
      end
   endtask

   task automatic test_str2mem();
      bit seen;
      int base = ack_cnt;
      logic [31:0] words[3];
      clear_logs();
      for (int i = 0; i < 3; i++) begin
         words[i] = $urandom;
         rx_src.push_back(words[i]);
      end
      rx_gap = 1;
      start_req(32'h200, 3, 3'b010);
      wait_ack(60, base, seen);
      drop_grant();
      repeat (3) @(negedge clk);
      rx_gap = 0;
      total++;
      if (!seen || ack_cnt != base + 1) begin
         bad++;
         $display("FAIL s2m_ack: got %0d acks, required 1", ack_cnt - base);
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (rd(32'h200 + 32'(i) * 32'd4) !== words[i]) begin
            bad++;
            $display("FAIL s2m_word%0d: got %h, required %h", i, rd(32'h200 + 32'(i) * 32'd4), words[i]);
         end
      end
      total++;
      if (wr_cyc_q.size() != 3 || ack_cyc != wr_cyc_q[2] + 1 || rx_src.size() != 0) begin
         bad++;
         $display("FAIL s2m_timing: got writes=%0d leftover=%0d ack=%0d, required 3 writes, ack after 3rd",
                  wr_cyc_q.size(), rx_src.size(), ack_cyc);
      end
   endtask

   task automatic test_zero_illegal();
      logic [2:0]       types[3]  = '{3'b011, 3'b111, 3'b000};
      logic [CNT_W-1:0] counts[3] = '{0, 5, 2};
      for (int k = 0; k < 3; k++) begin
         bit seen;
         int base = ack_cnt;
         int ebase = err_cnt;
         clear_logs();
         start_req(32'h700, counts[k], types[k]);
         wait_ack(10, base, seen);
         drop_grant();
         repeat (3) @(negedge clk);
         total++;
         if (!seen || ack_cyc != grant_cyc + 1 || ack_cnt != base + 1 ||
             wr_addr_q.size() != 0 || tx_q.size() != 0) begin
            bad++;
            $display("FAIL noop_type%0d: got acks=%0d at +%0d writes=%0d tx=%0d, required 1 ack at +1 no traffic",
                     types[k], ack_cnt - base, ack_cyc - grant_cyc, wr_addr_q.size(), tx_q.size());
         end
`ifdef DMA_ERR_EN
         total++;
         if (err_cnt - ebase != (types[k] == 3'b011 ? 0 : 1)) begin
            bad++;
            $display("FAIL noop_err%0d: got %0d err pulses, required %0d",
                     types[k], err_cnt - ebase, types[k] == 3'b011 ? 0 : 1);
         end
`else
         ebase = ebase + 0;
`endif
      end
   endtask

   task automatic test_grant_hold();
      bit seen;
      int base = ack_cnt;
      clear_logs();
      start_req(32'h500, 2, 3'b011);
      wait_ack(20, base, seen);
      repeat (10) @(posedge clk);
      #1;
      total++;
      if (!seen || ack_cnt != base + 1 || wr_addr_q.size() != 2) begin
         bad++;
         $display("FAIL hold_single: got acks=%0d writes=%0d, required 1 ack 2 writes", ack_cnt - base, wr_addr_q.size());
      end
      i_dma_grant = 1'b0;
      start_req(32'h600, 1, 3'b011);
      wait_ack(20, base + 1, seen);
      drop_grant();
      repeat (3) @(negedge clk);
      total++;
      if (!seen || ack_cnt != base + 2 || wr_addr_q.size() != 3 || wr_addr_q[wr_addr_q.size() - 1] !== 32'h600) begin
         bad++;
         $display("FAIL hold_restart: got acks=%0d writes=%0d, required 2 acks 3 writes ending at 600",
                  ack_cnt - base, wr_addr_q.size());
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      int base = ack_cnt;
      for (int i = 0; i < 4; i++) mem[32'h300 + 32'(i) * 32'd4] = 32'h1111_0000 + 32'(i);
      clear_logs();
      start_req(32'h303, 4, 3'b011);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      i_dma_grant = 1'b0;
      #1;
      total++;
      if (!outs_zero()) begin
         bad++;
         $display("FAIL midreset_outputs: got web=%h addrb=%h ack=%b, required all 0", o_web, o_addrb, o_dma_ack);
      end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (ack_cnt != base || wr_addr_q.size() != 1 || rd(32'h300) !== FILL || rd(32'h304) !== 32'h1111_0001) begin
         bad++;
         $display("FAIL midreset_abort: got acks=%0d writes=%0d w0=%h w1=%h, required no ack, only word 0 written",
                  ack_cnt - base, wr_addr_q.size(), rd(32'h300), rd(32'h304));
      end
      @(negedge clk);
      rst_n = 1'b1;
      clear_logs();
      start_req(32'h300, 4, 3'b011);
      wait_ack(20, base, seen);
      drop_grant();
      repeat (3) @(negedge clk);
      total++;
      if (!seen || ack_cnt != base + 1 || wr_addr_q.size() != 4 || wr_addr_q[3] !== 32'h30C) begin
         bad++;
         $display("FAIL midreset_recover: got acks=%0d writes=%0d, required 1 ack 4 writes to 300..30C",
                  ack_cnt - base, wr_addr_q.size());
      end
   endtask

   task automatic test_random();
      tx_mode = 2;
      rx_gap  = 2;
      for (int n = 0; n < 25; n++) begin
         logic [31:0]      a, a0;
         logic [CNT_W-1:0] c;
         logic [2:0]       t;
         bit               legal, ovf, exp_err, active, seen;
         logic [31:0]      exp_wa[$], exp_wd[$], exp_tx[$];
         int               base, ebase, r;
         r = int'($urandom_range(0, 9));
         t = (r < 3) ? 3'b001 : (r < 6) ? 3'b010 : (r < 9) ? 3'b011 : 3'($urandom_range(4, 7));
         c = CNT_W'($urandom_range(0, 6));
         a = $urandom;
         if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFE8 | (a & 32'h7);
         a0 = a & 32'hFFFF_FFFC;
         legal = (t == 3'b001 || t == 3'b010 || t == 3'b011);
         ovf = (64'(a0) + 64'(c) * 64'd4) > 64'h1_0000_0000;
`ifdef DMA_ERR_EN
         exp_err = !legal || (c != 0 && ovf);
`else
         exp_err = 1'b0;
`endif
         active = legal && c != 0 && !exp_err;
         if (active) begin
            for (int i = 0; i < int'(c); i++) begin
               logic [31:0] wa, w;
               wa = a0 + 32'(i) * 32'd4;
               w  = $urandom;
               if (t == 3'b001) exp_tx.push_back(rd(wa));
               if (t == 3'b010) begin
                  rx_src.push_back(w);
                  exp_wa.push_back(wa);
                  exp_wd.push_back(w);
               end
               if (t == 3'b011) begin
                  exp_wa.push_back(wa);
                  exp_wd.push_back(FILL);
               end
            end
         end
         base  = ack_cnt;
         ebase = err_cnt;
         clear_logs();
         start_req(a, c, t);
         wait_ack(40 * int'(c) + 20, base, seen);
         drop_grant();
         repeat (2) @(negedge clk);
         total++;
         if (!seen || ack_cnt != base + 1 || (!active && ack_cyc != grant_cyc + 1)) begin
            bad++;
            $display("FAIL rand%0d_ack: type=%0d count=%0d got acks=%0d at +%0d", n, t, c,
                     ack_cnt - base, ack_cyc - grant_cyc);
         end
         total++;
         if (wr_addr_q.size() != exp_wa.size() || tx_q.size() != exp_tx.size()) begin
            bad++;
            $display("FAIL rand%0d_len: got writes=%0d tx=%0d, required writes=%0d tx=%0d",
                     n, wr_addr_q.size(), tx_q.size(), exp_wa.size(), exp_tx.size());
         end else begin
            for (int i = 0; i < exp_wa.size(); i++) begin
               total++;
               if (wr_addr_q[i] !== exp_wa[i] || wr_data_q[i] !== exp_wd[i]) begin
                  bad++;
                  $display("FAIL rand%0d_wr%0d: got %h@%h, required %h@%h", n, i,
                           wr_data_q[i], wr_addr_q[i], exp_wd[i], exp_wa[i]);
               end
            end
            for (int i = 0; i < exp_tx.size(); i++) begin
               total++;
               if (tx_q[i] !== exp_tx[i]) begin
                  bad++;
                  $display("FAIL rand%0d_tx%0d: got %h, required %h", n, i, tx_q[i], exp_tx[i]);
               end
            end
         end
`ifdef DMA_ERR_EN
         total++;
         if (err_cnt - ebase != int'(exp_err)) begin
            bad++;
            $display("FAIL rand%0d_err: got %0d err pulses, required %0d", n, err_cnt - ebase, int'(exp_err));
         end
`endif
         rx_src.delete();
      end
      tx_mode = 1;
      rx_gap  = 0;
   endtask

   task automatic test_invariants();
      total++;
      if (viol != 0) begin
         bad++;
         $display("FAIL protocol_invariants: got %0d violations, required 0", viol);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_mem2str();
      test_str2mem();
      test_zero_illegal();
      test_grant_hold();
      test_reset_mid();
      test_random();
      test_invariants();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
